// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers through EX/ME/WB and produces the
// stall, flush, bubble and mul/div hold controls for the 5-stage pipeline.
//
// state | meaning
// IDLE  | no multi-cycle op occupying EX
// BUSY  | mul/div in EX, counting down its remaining stall cycles
module hazard_scoreboard #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_id,
  input  logic       RUWr_id,
  input  logic       DMRd_id,
  input  logic       muldiv_id,
  input  logic       branch_taken_ex,
  output logic       stall_if,
  output logic       stall_id,
  output logic       hold_ex,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic [4:0] rd_ex,
  output logic [4:0] rd_me,
  output logic [4:0] rd_wb,
  output logic       RUWr_ex,
  output logic       RUWr_me,
  output logic       RUWr_wb
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam bit         MULTI    = (MULDIV_CYCLES > 1);
  // The first stall cycle is spent in IDLE, so BUSY counts the remaining ones.
  localparam logic [3:0] CNT_LOAD = MULTI ? 4'(MULDIV_CYCLES - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic valid_ex, load_ex, muldiv_ex;
  logic mul_in_ex, cnt_tc, mul_start, mul_stall, load_use;

  assign mul_in_ex = valid_ex & muldiv_ex;
  assign cnt_tc    = (cnt == 4'd0);
  assign mul_start = (state == IDLE) && mul_in_ex && MULTI;
  assign mul_stall = mul_start || ((state == BUSY) && !cnt_tc);

  assign load_use = valid_ex && load_ex && (rd_ex != 5'd0) && valid_id &&
                    ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mul_start) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_tc) state_nxt = IDLE;
        else        cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Priority: mul/div hold, then branch redirect, then load-use.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    hold_ex     = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    muldiv_busy = (state == BUSY);
    muldiv_done = ((state == BUSY) && cnt_tc) ||
                  ((state == IDLE) && mul_in_ex && !MULTI);
    if (mul_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      hold_ex  = 1'b1;
    end else if (branch_taken_ex) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ex     <= 5'd0;
      RUWr_ex   <= 1'b0;
      load_ex   <= 1'b0;
      muldiv_ex <= 1'b0;
      valid_ex  <= 1'b0;
      rd_me     <= 5'd0;
      RUWr_me   <= 1'b0;
      rd_wb     <= 5'd0;
      RUWr_wb   <= 1'b0;
    end else begin
      rd_wb   <= rd_me;
      RUWr_wb <= RUWr_me;
      if (hold_ex) begin
        rd_me   <= 5'd0;
        RUWr_me <= 1'b0;
      end else begin
        rd_me   <= rd_ex;
        RUWr_me <= RUWr_ex;
        if (bubble_ex || !valid_id) begin
          rd_ex     <= 5'd0;
          RUWr_ex   <= 1'b0;
          load_ex   <= 1'b0;
          muldiv_ex <= 1'b0;
          valid_ex  <= 1'b0;
        end else begin
          rd_ex     <= rd_id;
          RUWr_ex   <= RUWr_id;
          load_ex   <= DMRd_id;
          muldiv_ex <= muldiv_id;
          valid_ex  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table for single-cycle
// hazard decisions, hand sequences plus a WB scoreboard for multi-cycle cases.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_id, RUWr_id, DMRd_id, muldiv_id, branch_taken_ex;
  logic [4:0] rs1_id, rs2_id, rd_id;

  logic       a_stall_if, a_stall_id, a_hold_ex, a_bubble_ex, a_flush_id, a_busy, a_done;
  logic [4:0] a_rd_ex, a_rd_me, a_rd_wb;
  logic       a_w_ex, a_w_me, a_w_wb;
  logic       b_stall_if, b_stall_id, b_hold_ex, b_bubble_ex, b_flush_id, b_busy, b_done;
  logic [4:0] b_rd_ex, b_rd_me, b_rd_wb;
  logic       b_w_ex, b_w_me, b_w_wb;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MULDIV_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .RUWr_id(RUWr_id), .DMRd_id(DMRd_id), .muldiv_id(muldiv_id),
    .branch_taken_ex(branch_taken_ex),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .hold_ex(a_hold_ex),
    .bubble_ex(a_bubble_ex), .flush_id(a_flush_id), .muldiv_busy(a_busy),
    .muldiv_done(a_done), .rd_ex(a_rd_ex), .rd_me(a_rd_me), .rd_wb(a_rd_wb),
    .RUWr_ex(a_w_ex), .RUWr_me(a_w_me), .RUWr_wb(a_w_wb));

  hazard_scoreboard #(.MULDIV_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .RUWr_id(RUWr_id), .DMRd_id(DMRd_id), .muldiv_id(muldiv_id),
    .branch_taken_ex(branch_taken_ex),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .hold_ex(b_hold_ex),
    .bubble_ex(b_bubble_ex), .flush_id(b_flush_id), .muldiv_busy(b_busy),
    .muldiv_done(b_done), .rd_ex(b_rd_ex), .rd_me(b_rd_me), .rd_wb(b_rd_wb),
    .RUWr_ex(b_w_ex), .RUWr_me(b_w_me), .RUWr_wb(b_w_wb));

  // ctrl order: stall_if, stall_id, hold_ex, bubble_ex, flush_id, muldiv_busy, muldiv_done
  wire [6:0]  ctrl_a = {a_stall_if, a_stall_id, a_hold_ex, a_bubble_ex, a_flush_id, a_busy, a_done};
  wire [6:0]  ctrl_b = {b_stall_if, b_stall_id, b_hold_ex, b_bubble_ex, b_flush_id, b_busy, b_done};
  wire [17:0] trk_a  = {a_rd_ex, a_w_ex, a_rd_me, a_w_me, a_rd_wb, a_w_wb};
  wire [17:0] trk_b  = {b_rd_ex, b_w_ex, b_rd_me, b_w_me, b_rd_wb, b_w_wb};

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // WB scoreboard: expected {rd_wb, RUWr_wb} for a given cycle and instance.
  typedef struct packed {
    logic [31:0] cyc;
    logic        dut;
    logic [4:0]  rd;
    logic        w;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  always @(posedge clk) begin
    #3;
    while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
      sb_e = sb.pop_front();
      if (sb_e.dut == 1'b0) chk("wb_a", 32'({a_rd_wb, a_w_wb}), 32'({sb_e.rd, sb_e.w}));
      else                  chk("wb_b", 32'({b_rd_wb, b_w_wb}), 32'({sb_e.rd, sb_e.w}));
    end
  end

  task automatic push(input int c, input logic d, input logic [4:0] r, input logic w);
    sb.push_back('{cyc: 32'(c), dut: d, rd: r, w: w});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic w, input logic ld, input logic md);
    valid_id = v; rs1_id = r1; rs2_id = r2; rd_id = rd;
    RUWr_id = w; DMRd_id = ld; muldiv_id = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    branch_taken_ex = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  typedef struct packed {
    logic       pv;
    logic [4:0] prd;
    logic       pw, pld, pmul;
    logic       cv;
    logic [4:0] rs1, rs2;
    logic       br;
    logic [6:0] ctrl;
    logic [4:0] rd_ex;
  } vec_t;
  vec_t vecs[11];

  int c;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          pv    prd   pw    pld   pmul  cv    rs1   rs2   br    ctrl         rd_ex
    vecs[0]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 7'b1101000, 5'd5};
    vecs[1]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 7'b1101000, 5'd5};
    vecs[2]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 7'b0000000, 5'd5};
    vecs[3]  = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 7'b0000000, 5'd0};
    vecs[4]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 1'b0, 7'b0000000, 5'd5};
    vecs[5]  = '{1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 7'b0000000, 5'd5};
    vecs[6]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 1'b1, 7'b0001100, 5'd5};
    vecs[7]  = '{1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 7'b0001100, 5'd5};
    vecs[8]  = '{1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 1'b1, 7'b1110000, 5'd7};
    vecs[9]  = '{1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 7'b1110000, 5'd7};
    vecs[10] = '{1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 7'b0000000, 5'd0};

    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ctrl_a", 32'(ctrl_a), 32'd0);
    chk("reset_trk_a",  32'(trk_a),  32'd0);
    chk("reset_ctrl_b", 32'(ctrl_b), 32'd0);
    chk("reset_trk_b",  32'(trk_b),  32'd0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(vecs[i].pv, 5'd0, 5'd0, vecs[i].prd, vecs[i].pw, vecs[i].pld, vecs[i].pmul);
      tick();
      drive(vecs[i].cv, vecs[i].rs1, vecs[i].rs2, 5'd6, 1'b1, 1'b0, 1'b0);
      branch_taken_ex = vecs[i].br;
      #1;
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_a), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_rd_ex", i), 32'(a_rd_ex), 32'(vecs[i].rd_ex));
    end

    // lw x5 ; add x6,x5,x1 -> one stall cycle then a bubble travels down
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    c = cyc;
    push(c + 3, 1'b0, 5'd5, 1'b1);
    push(c + 4, 1'b0, 5'd0, 1'b0);
    push(c + 5, 1'b0, 5'd6, 1'b1);
    tick();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 32'(ctrl_a), 32'(7'b1101000));
    tick();
    #1;
    chk("lu_release", 32'(ctrl_a), 32'd0);
    chk("lu_ex_bubble", 32'({a_rd_ex, a_w_ex}), 32'd0);
    chk("lu_rd_me", 32'(a_rd_me), 32'd5);
    tick();
    idle();
    #1;
    chk("lu_add_ex", 32'(a_rd_ex), 32'd6);
    drain();

    // mul x7 with MULDIV_CYCLES=4; branch pulse during hold must be ignored
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    c = cyc;
    push(c + 3, 1'b0, 5'd0, 1'b0);
    push(c + 4, 1'b0, 5'd0, 1'b0);
    push(c + 5, 1'b0, 5'd0, 1'b0);
    push(c + 6, 1'b0, 5'd7, 1'b1);
    push(c + 7, 1'b0, 5'd10, 1'b1);
    tick();
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("md_c1_ctrl", 32'(ctrl_a), 32'(7'b1110000));
    chk("md_c1_rd_ex", 32'(a_rd_ex), 32'd7);
    tick();
    branch_taken_ex = 1'b1;
    #1;
    chk("md_c2_ctrl", 32'(ctrl_a), 32'(7'b1110010));
    chk("md_c2_rd_me", 32'(a_rd_me), 32'd0);
    tick();
    branch_taken_ex = 1'b0;
    #1;
    chk("md_c3_ctrl", 32'(ctrl_a), 32'(7'b1110010));
    chk("md_c3_me", 32'({a_rd_me, a_w_me}), 32'd0);
    tick();
    #1;
    chk("md_c4_done", 32'(ctrl_a), 32'(7'b0000011));
    chk("md_c4_rd_ex", 32'(a_rd_ex), 32'd7);
    tick();
    idle();
    #1;
    chk("md_c5_ctrl", 32'(ctrl_a), 32'd0);
    chk("md_c5_rd_me", 32'(a_rd_me), 32'd7);
    chk("md_c5_rd_ex", 32'(a_rd_ex), 32'd10);
    drain();

    // reset while BUSY aborts on the first reset edge
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    #1;
    chk("rb_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    tick();
    #1;
    chk("rb_abort_ctrl", 32'(ctrl_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rb_after_ctrl", 32'(ctrl_a), 32'd0);
    chk("rb_after_trk", 32'(trk_a), 32'd0);

    // MULDIV_CYCLES=1: mul x8 ; div x9 back to back, no stalls
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
    c = cyc;
    push(c + 3, 1'b1, 5'd8, 1'b1);
    push(c + 4, 1'b1, 5'd9, 1'b1);
    tick();
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    chk("b2b_done1", 32'(ctrl_b), 32'(7'b0000001));
    tick();
    idle();
    #1;
    chk("b2b_done2", 32'(ctrl_b), 32'(7'b0000001));
    chk("b2b_rd_ex", 32'(b_rd_ex), 32'd9);
    tick();
    #1;
    chk("b2b_quiet", 32'(ctrl_b), 32'd0);
    drain();

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer-side companion to the EX-stage forwarding logic in the 5-stage RISC-V pipeline. It tracks in-flight destination registers through the EX/ME/WB stages and publishes the registered rd/RUWr values that forwarding consumes. It also generates the stall, flush and bubble controls for three cases: load-use hazards, taken-branch redirects, and a multi-cycle mul/div unit occupying EX.

Parameters:
MULDIV_CYCLES, 4, total EX occupancy in cycles of a mul/div instruction; legal range 1..15.

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous, active-high reset
valid_id  input  1  ID stage holds a real instruction
rs1_id  input  5  ID source register 1
rs2_id  input  5  ID source register 2
rd_id  input  5  ID destination register
RUWr_id  input  1  ID instruction writes the register file
DMRd_id  input  1  ID instruction is a load
muldiv_id  input  1  ID instruction is mul/div
branch_taken_ex  input  1  EX resolved a taken branch or jump
stall_if  output  1  hold PC
stall_id  output  1  hold the IF/ID register
hold_ex  output  1  hold the ID/EX register (mul/div busy)
bubble_ex  output  1  load a NOP into ID/EX on the next edge
flush_id  output  1  load a NOP into IF/ID on the next edge
muldiv_busy  output  1  FSM in BUSY
muldiv_done  output  1  one-cycle pulse on the final mul/div EX cycle
rd_ex, rd_me, rd_wb  output  5 each  tracked destinations
RUWr_ex, RUWr_me, RUWr_wb  output  1 each  tracked write enables

Behaviour:
- Reset:
  - All tracked registers (rd_*, RUWr_*, internal load_ex, muldiv_ex, valid_ex) are 0.
  - FSM is IDLE, counter is 0.
  - All control outputs are 0.
  - Reset asserted mid-BUSY aborts to IDLE on the same edge.
- Tracking pipeline, one stage per clock:
  - Normal: EX <= ID fields gated by valid_id; ME <= EX; WB <= ME.
  - bubble_ex: EX <= zeros (RUWr=0, rd=0, load=0, muldiv=0, valid=0).
  - hold_ex: EX keeps its value, ME <= zeros, WB <= ME.
- Load-use hazard:
  - Condition: valid_ex & load_ex & rd_ex!=0 & valid_id & (rd_ex==rs1_id | rd_ex==rs2_id).
  - Response: stall_if=stall_id=1, bubble_ex=1.
  - Exactly one stall cycle results, because the load moves to ME on the next edge.
- Branch taken (branch_taken_ex=1):
  - flush_id=1 and bubble_ex=1; stall_if=stall_id=0.
  - Branch overrides a simultaneous load-use stall.
- Mul/div FSM (IDLE, BUSY):
  - IDLE with valid_ex & muldiv_ex & MULDIV_CYCLES>1: stall_if=stall_id=hold_ex=1, counter <= MULDIV_CYCLES-2, go to BUSY.
  - BUSY with counter!=0: stalls asserted, counter decrements.
  - BUSY with counter==0: stalls deasserted, muldiv_done=1, go to IDLE; the instruction advances on this edge.
  - MULDIV_CYCLES=1: no stall; muldiv_done pulses in the EX cycle.
  - Result: EX occupancy is MULDIV_CYCLES cycles, of which MULDIV_CYCLES-1 are stall cycles.
  - hold_ex and mul/div stalls take priority over load-use (a mul/div in EX is never a load).
  - branch_taken_ex is ignored while hold_ex=1.
- Register x0: rd=0 never triggers a hazard, even with RUWr=1.
- Timing: all control outputs are combinational from the current tracked state and the ID inputs; tracked outputs are registered.
- Back-to-back mul/div: the second mul/div enters EX on the done edge and restarts the FSM from IDLE on the following cycle.

Test Plan:
- Reset: assert rst for 2 cycles while in BUSY -> all outputs 0, muldiv_busy=0 on the cycle after release.
- Load-use: lw x5 in ID, then add x6,x5,x1 -> one cycle of stall_if=stall_id=bubble_ex=1; next cycle rd_ex=0, RUWr_ex=0, rd_me=5.
- Load with no dependency, or rd=x0 (lw x0 then add x6,x0,x0) -> no stall and no bubble.
- Branch taken coinciding with a load-use condition -> flush_id=1, bubble_ex=1, stall_if=0.
- Mul/div with MULDIV_CYCLES=4: mul x7 in EX -> stall_if/stall_id/hold_ex high for 3 cycles, muldiv_done high on cycle 4, rd_me=7 on the cycle after; ME holds zeros during the stall.
- MULDIV_CYCLES=1, back-to-back mul x8 then div x9 -> no stalls, muldiv_done pulses on 2 consecutive cycles, rd_wb sequence 8 then 9.
